// File: rtl/plot_feeder_pkg.sv
// rtl/plot_feeder_pkg.sv - shared types and widths for the plotter pixel feeder
// Purpose: FSM state type, default image geometry and bus widths used by
//          plot_pixel_feeder, serpentine_counter and plot_pixel_feeder_if.
// Ports:   none (package).
package plot_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } feeder_state_t;

  localparam int IMG_W_DEF = 80;
  localparam int IMG_H_DEF = 106;
  localparam int ADDR_W    = 17;
  localparam int COORD_W   = 7;

endpackage

// File: rtl/plot_pixel_feeder_if.sv
// rtl/plot_pixel_feeder_if.sv - control, handshake and BRAM read signal bundle
// Purpose: groups the feeder's control inputs, BRAM read port and plotter
//          handshake so they can be passed as one port.
// Ports:   master = feeder side (drives addr/pixel/status),
//          slave  = surrounding system (drives start/enable/ready/bram data).
interface plot_pixel_feeder_if;
  import plot_feeder_pkg::*;

  logic               start_in;
  logic               enable_in;
  logic               ready_next_pixel_in;
  logic               bram_data_in;
  logic [ADDR_W-1:0]  addr_out;
  logic               pixel_value_out;
  logic               pixel_valid_out;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic               busy_out;
  logic               done_out;
  logic               overrun_out;

  modport master (
    input  start_in, enable_in, ready_next_pixel_in, bram_data_in,
    output addr_out, pixel_value_out, pixel_valid_out, x_out, y_out,
           busy_out, done_out, overrun_out
  );

  modport slave (
    output start_in, enable_in, ready_next_pixel_in, bram_data_in,
    input  addr_out, pixel_value_out, pixel_valid_out, x_out, y_out,
           busy_out, done_out, overrun_out
  );

endinterface

// File: rtl/serpentine_counter.sv
// rtl/serpentine_counter.sv - serpentine x/y walker with incremental BRAM address
// Purpose: walks the image left-to-right on even rows and right-to-left on odd
//          rows, keeping the row-major address without a multiplier.
// Ports:   clk, rst_n (async active-low); clear -> back to (0,0);
//          advance -> step one pixel; x, y, addr -> current position;
//          last -> current pixel is the final one of the image.
module serpentine_counter import plot_feeder_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic              odd;
  logic              row_end;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_base;

  assign row_end   = odd ? (x == '0) : (x == COORD_W'(IMG_W - 1));
  assign last      = row_end && (y == COORD_W'(IMG_H - 1));
  assign next_base = row_base + ADDR_W'(IMG_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      odd      <= 1'b0;
      row_base <= '0;
      addr     <= '0;
    end else if (clear) begin
      x        <= '0;
      y        <= '0;
      odd      <= 1'b0;
      row_base <= '0;
      addr     <= '0;
    end else if (advance) begin
      if (row_end) begin
        // Drop straight down: x stays put, the direction flips.
        y        <= y + COORD_W'(1);
        odd      <= ~odd;
        row_base <= next_base;
        addr     <= next_base + ADDR_W'(x);
      end else if (odd) begin
        x    <= x - COORD_W'(1);
        addr <= addr - ADDR_W'(1);
      end else begin
        x    <= x + COORD_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/plot_pixel_feeder.sv
// rtl/plot_pixel_feeder.sv - streams the B/W image from BRAM to the plotter
// Purpose: fetches each pixel in serpentine order, waits out the BRAM read
//          latency, presents it and advances on each ready rising edge.
// Ports:   clk_65mhz, cpu_resetn (async active-low);
//          bus (master): start/enable/ready/bram data in,
//          addr/pixel/valid/x/y/busy/done/overrun out.
module plot_pixel_feeder import plot_feeder_pkg::*; #(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                 clk_65mhz,
  input  logic                 cpu_resetn,
  plot_pixel_feeder_if.master  bus
);

  localparam int CNT_W = $clog2(BRAM_LATENCY + 2);

  feeder_state_t      state, state_next;
  logic               ready_prev;
  logic               req;
  logic [CNT_W-1:0]   wait_cnt;
  logic               start_run, fetch_done, advance, finish;
  logic               pixel_value, pixel_valid, busy, done, overrun;
  logic [COORD_W-1:0] x, y;
  logic [ADDR_W-1:0]  addr;
  logic               last;

  // ready_prev resets high so a level already high is not taken as an edge.
  assign req = bus.ready_next_pixel_in & ~ready_prev & bus.enable_in;

  always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    fetch_done = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start_in) begin
          start_run  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (wait_cnt == '0) begin
          fetch_done = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (req) begin
          if (last) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      ready_prev  <= 1'b1;
      wait_cnt    <= '0;
      pixel_value <= 1'b0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ready_prev <= bus.ready_next_pixel_in;

      if (start_run || advance)
        wait_cnt <= CNT_W'(BRAM_LATENCY);
      else if (state == FETCH && wait_cnt != '0)
        wait_cnt <= wait_cnt - CNT_W'(1);

      if (fetch_done) begin
        pixel_value <= bus.bram_data_in;
        pixel_valid <= 1'b1;
      end else if (start_run || advance || finish) begin
        pixel_valid <= 1'b0;
      end

      if (start_run) begin
        busy    <= 1'b1;
        done    <= 1'b0;
        overrun <= 1'b0;
      end else if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      // The plotter asked for more before the current pixel was shown.
      if (!start_run && state == FETCH && req)
        overrun <= 1'b1;
    end
  end

  serpentine_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_walk (
    .clk     (clk_65mhz),
    .rst_n   (cpu_resetn),
    .clear   (start_run),
    .advance (advance),
    .x       (x),
    .y       (y),
    .addr    (addr),
    .last    (last)
  );

  assign bus.addr_out        = addr;
  assign bus.pixel_value_out = pixel_value;
  assign bus.pixel_valid_out = pixel_valid;
  assign bus.x_out           = x;
  assign bus.y_out           = y;
  assign bus.busy_out        = busy;
  assign bus.done_out        = done;
  assign bus.overrun_out     = overrun;

endmodule

// File: tb/tb_plot_pixel_feeder.sv
// tb/tb_plot_pixel_feeder.sv - scoreboard bench for plot_pixel_feeder
module tb_plot_pixel_feeder;

  localparam int IMG_W = 80;
  localparam int IMG_H = 106;

  typedef struct {
    int   x;
    int   y;
    int   addr;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  plot_pixel_feeder_if bus ();

  plot_pixel_feeder #(
    .IMG_W        (IMG_W),
    .IMG_H        (IMG_H),
    .BRAM_LATENCY (2)
  ) dut (
    .clk_65mhz  (clk),
    .cpu_resetn (rst_n),
    .bus        (bus)
  );

  // Registered-output BRAM: two cycles from address change to data.
  logic [16:0] addr_q;
  always @(posedge clk) begin
    addr_q           <= bus.addr_out;
    bus.bram_data_in <= addr_q[0] ^ addr_q[7];
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   mx, my;
  exp_t exp_q[$];
  logic valid_d = 1'b0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_step();
    if (my % 2 == 0) begin
      if (mx < IMG_W - 1) mx++;
      else my++;
    end else begin
      if (mx > 0) mx--;
      else my++;
    end
  endfunction

  function automatic logic model_last();
    return (my == IMG_H - 1) && ((my % 2 == 0) ? (mx == IMG_W - 1) : (mx == 0));
  endfunction

  task automatic push_exp();
    exp_t e;
    e.x    = mx;
    e.y    = my;
    e.addr = my * IMG_W + mx;
    e.val  = e.addr[0] ^ e.addr[7];
    exp_q.push_back(e);
  endtask

  task automatic req_edge();
    bus.ready_next_pixel_in = 1'b1;
    tick();
    bus.ready_next_pixel_in = 1'b0;
    tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.pixel_valid_out && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout", bus.pixel_valid_out, 1);
  endtask

  task automatic press();
    logic lst;
    lst = model_last();
    if (!lst) begin
      model_step();
      push_exp();
    end
    req_edge();
    if (!lst) wait_valid();
  endtask

  task automatic do_start();
    mx = 0;
    my = 0;
    push_exp();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
  endtask

  // Scoreboard: every newly presented pixel must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_d = 1'b0;
    end else begin
      if (bus.pixel_valid_out && !valid_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("px_x", bus.x_out, e.x);
          check("px_y", bus.y_out, e.y);
          check("px_addr", bus.addr_out, e.addr);
          check("px_value", bus.pixel_value_out, e.val);
        end
      end
      valid_d = bus.pixel_valid_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                   = 1'b0;
    bus.start_in            = 1'b0;
    bus.enable_in           = 1'b1;
    bus.ready_next_pixel_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();

    // Idle after reset with ready held high: nothing moves.
    check("rst_addr", bus.addr_out, 0);
    check("rst_valid", bus.pixel_valid_out, 0);
    check("rst_value", bus.pixel_value_out, 0);
    check("rst_x", bus.x_out, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_done", bus.done_out, 0);
    check("rst_overrun", bus.overrun_out, 0);
    bus.ready_next_pixel_in = 1'b0;
    tick();

    // First fetch latency.
    do_start();
    check("start_addr", bus.addr_out, 0);
    check("start_busy", bus.busy_out, 1);
    check("lat_c1", bus.pixel_valid_out, 0);
    tick();
    check("lat_c2", bus.pixel_valid_out, 0);
    tick();
    check("lat_c3", bus.pixel_valid_out, 0);
    tick();
    check("lat_c4", bus.pixel_valid_out, 1);
    check("first_value", bus.pixel_value_out, 0);

    repeat (5) press();

    // Ready edge with enable low is lost.
    bus.enable_in = 1'b0;
    req_edge();
    repeat (3) tick();
    check("en_valid", bus.pixel_valid_out, 1);
    check("en_x", bus.x_out, mx);
    check("en_y", bus.y_out, my);
    bus.enable_in = 1'b1;
    press();

    // Second edge lands while fetching: flagged, no extra step.
    model_step();
    push_exp();
    bus.ready_next_pixel_in = 1'b1;
    tick();
    bus.ready_next_pixel_in = 1'b0;
    tick();
    bus.ready_next_pixel_in = 1'b1;
    tick();
    bus.ready_next_pixel_in = 1'b0;
    tick();
    check("ovr_flag", bus.overrun_out, 1);
    wait_valid();
    check("ovr_x", bus.x_out, mx);

    // Start while busy is ignored.
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    repeat (4) tick();
    check("midstart_valid", bus.pixel_valid_out, 1);
    check("midstart_x", bus.x_out, mx);
    check("midstart_busy", bus.busy_out, 1);
    check("midstart_overrun", bus.overrun_out, 1);

    while (!(mx == 37 && my == 12)) press();
    check("pos_addr", bus.addr_out, 997);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.pixel_valid_out, 0);
    check("arst_x", bus.x_out, 0);
    check("arst_y", bus.y_out, 0);
    check("arst_addr", bus.addr_out, 0);
    check("arst_busy", bus.busy_out, 0);
    check("arst_overrun", bus.overrun_out, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_start();
    wait_valid();
    check("restart_x", bus.x_out, 0);
    check("restart_y", bus.y_out, 0);

    // Full run including both row-end turns and the final pixel.
    for (int i = 1; i <= IMG_W * IMG_H; i++) begin
      press();
      if (i == 79) begin
        check("wrap0_x", bus.x_out, 79);
        check("wrap0_y", bus.y_out, 0);
      end
      if (i == 80) begin
        check("wrap1_x", bus.x_out, 79);
        check("wrap1_y", bus.y_out, 1);
        check("wrap1_addr", bus.addr_out, 159);
      end
      if (i == 81) begin
        check("wrap2_x", bus.x_out, 78);
        check("wrap2_addr", bus.addr_out, 158);
      end
      if (i == IMG_W * IMG_H - 1) begin
        check("last_x", bus.x_out, 0);
        check("last_y", bus.y_out, 105);
        check("last_addr", bus.addr_out, 8400);
      end
    end
    check("done_flag", bus.done_out, 1);
    check("done_busy", bus.busy_out, 0);
    check("done_valid", bus.pixel_valid_out, 0);

    do_start();
    check("rerun_done", bus.done_out, 0);
    check("rerun_busy", bus.busy_out, 1);
    check("rerun_addr", bus.addr_out, 0);
    wait_valid();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/plot_pixel_feeder.md
Name: plot_pixel_feeder

Overview:
Reads the 1-bit averaged black/white image (80x106, row-major, 1 bit per word) out of its dual-port BRAM and streams it pixel by pixel to plotter_control over the pixel_value / ready_next_pixel handshake.
Pixels are visited in serpentine order so the pen never retraces a row:
- even rows run left to right;
- odd rows run right to left.
The block sits on clk_65mhz between the black_white BRAM read port and plotter_control.

Parameters:
IMG_W, 80, image width in pixels (x range 0..IMG_W-1)
IMG_H, 106, image height in rows (y range 0..IMG_H-1)
BRAM_LATENCY, 2, cycles from addr_out change to valid bram_data_in (registered-output BRAM)

Ports:
clk_65mhz  input  1  system clock
cpu_resetn  input  1  asynchronous active-low reset
start_in  input  1  one-cycle pulse: begin plotting from (0,0)
enable_in  input  1  plotter enable; ready edges are ignored while low
ready_next_pixel_in  input  1  level from plotter_control; rising edge = current pixel consumed, next requested
bram_data_in  input  1  BRAM read data (doutb)
addr_out  output  17  BRAM read address (addrb)
pixel_value_out  output  1  current pixel to plot (to pixel_value_in)
pixel_valid_out  output  1  high while pixel_value_out is valid (PRESENT state)
x_out  output  7  x of presented pixel
y_out  output  7  y of presented pixel
busy_out  output  1  high from start accepted until DONE
done_out  output  1  sticky high after last pixel consumed; cleared by start_in
overrun_out  output  1  sticky: ready edge arrived during FETCH; cleared by start_in

Behaviour:
- Reset (async, cpu_resetn=0):
  - state=IDLE; all outputs 0.
  - Edge-detect history register (ready_prev) = 1, so a ready level already high after reset or start is not an edge.
- Edge detect: req = ready_next_pixel_in & ~ready_prev & enable_in. ready_prev updates every cycle.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start_in=1 -> FETCH.
  - x=0, y=0, row_base=0, addr_out=0 (registered, valid the cycle after start).
  - Clear done_out/overrun_out, busy_out=1.
  - Load the wait counter with BRAM_LATENCY.
- FETCH:
  - Counter decrements each cycle; when it reaches 0, capture bram_data_in into pixel_value_out, set pixel_valid_out=1 -> PRESENT.
  - With BRAM_LATENCY=2, pixel_valid_out rises 4 cycles after the start_in edge.
  - req during FETCH: ignored (no advance), overrun_out<=1.
- PRESENT:
  - pixel_value_out, x_out, y_out held stable.
  - On req, pixel_valid_out<=0 and the serpentine counter advances:
    - Even row, x<IMG_W-1: x+1.
    - Odd row, x>0: x-1.
    - Row end (even x=IMG_W-1 or odd x=0): y+1, x unchanged, row_base+=IMG_W.
  - addr_out = row_base + x, registered, computed incrementally; no multiplier.
  - If the consumed pixel was the last one (y=IMG_H-1 at the row end) -> DONE. Otherwise -> FETCH.
- DONE: busy_out=0, done_out=1, pixel_valid_out=0. start_in restarts the run (same as from IDLE).
- start_in while busy (FETCH/PRESENT): ignored.
- enable_in low mid-run: the state machine holds position. Rising edges seen while enable_in is low are lost, not queued.
- Reset mid-run: immediate return to IDLE. Position is lost and the next start begins at (0,0).
- Widths:
  - x/y are 7-bit unsigned; addr 17-bit.
  - Maximum addr = IMG_W*IMG_H-1 = 8479.
  - With IMG_H=106 the last row (y=105) is odd, so the final pixel is (0,105), addr 8400.

Decomposition:
- Package plot_feeder_pkg: feeder_state_t enum (IDLE, FETCH, PRESENT, DONE); defaults IMG_W_DEF=80, IMG_H_DEF=106; ADDR_W=17, COORD_W=7.
- Sub-module serpentine_counter:
  - holds x, y, row_base, direction;
  - inputs: clear, advance;
  - outputs: x, y, addr, last.
- The FSM, edge detect and wait counter stay in plot_pixel_feeder.

Test Plan:
- Reset, no start: hold cpu_resetn=0 then release -> all outputs 0, state IDLE; ready_next_pixel_in held high gives no req.
- Start with BRAM model (latency 2, data=addr[0]^addr[7]) -> addr_out=0 one cycle after start, pixel_valid_out=1 four cycles after start, pixel_value_out=0, x_out=0, y_out=0.
- Serpentine wrap: 80 ready rising edges -> presented (79,0) then (79,1) with addr 159; next edge -> (78,1), addr 158.
- Full run: 8480 req edges -> last presented (0,105), addr 8400; after the final edge done_out=1, busy_out=0, pixel_valid_out=0; start_in clears done_out and re-presents addr 0.
- Protocol violations:
  - ready edge during FETCH -> overrun_out=1, position unchanged;
  - ready edge with enable_in=0 -> no advance;
  - start_in pulse mid-run -> ignored.
- Reset mid-run at (37,12) -> outputs 0 asynchronously; next start presents (0,0).
